// File: rtl/formation_ctrl.sv
// Enemy formation controller: one origin plus an alive mask, marching between X limits,
// descending and speeding up at each edge, with hit retirement and a registered position query.
module formation_ctrl #(
    parameter int unsigned ROWS        = 4,
    parameter int unsigned COLS        = 10,
    parameter int unsigned XW          = 11,
    parameter int unsigned DX          = 30,
    parameter int unsigned DY          = 30,
    parameter int unsigned ROW_SHIFT   = 10,
    parameter int unsigned X_INIT      = 150,
    parameter int unsigned Y_INIT      = 40,
    parameter int unsigned X_MIN       = 150,
    parameter int unsigned X_MAX       = 760,
    parameter int unsigned DESCEND     = 50,
    parameter int unsigned Y_LAND      = 400,
    parameter int unsigned SPEED_MAX   = 15,
    parameter int unsigned MOVE_PERIOD = 2097152,
    localparam int unsigned RW = $clog2(ROWS),
    localparam int unsigned CW = $clog2(COLS),
    localparam int unsigned N  = ROWS * COLS,
    localparam int unsigned NW = $clog2(N + 1),
    localparam int unsigned SW = $clog2(SPEED_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          pause,
    input  logic          hit_valid,
    input  logic [RW-1:0] hit_row,
    input  logic [CW-1:0] hit_col,
    input  logic [RW-1:0] q_row,
    input  logic [CW-1:0] q_col,
    output logic [XW-1:0] q_x,
    output logic [XW-1:0] q_y,
    output logic          q_alive,
    output logic [N-1:0]  alive,
    output logic [NW-1:0] alive_count,
    output logic          hit_ack,
    output logic          direction,
    output logic [SW-1:0] speed,
    output logic [2:0]    state
);
    localparam int unsigned MW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    // Edge math width: room for sign and for ext+step without wrapping.
    localparam int unsigned EW = XW + 2;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StMarch   = 3'd1,
        StCleared = 3'd2,
        StLanded  = 3'd3
    } state_e;

    state_e        state_q;
    logic [XW-1:0] org_x;
    logic [XW-1:0] org_y;
    logic          pend_descent;
    logic [MW-1:0] move_cnt;

    logic [XW-1:0] max_off, min_off, off;
    logic          landed;
    logic          hit_live;
    logic [N-1:0]  hit_mask;
    logic          q_in, q_alive_d;
    logic [XW-1:0] qx_calc, qy_calc;
    logic [XW-1:0] step_x;
    logic signed [EW-1:0] right_s, left_s, step_s;
    logic          can_right, can_left;

    assign state = state_q;

    always_comb begin
        max_off   = '0;
        min_off   = '1;
        off       = '0;
        landed    = 1'b0;
        hit_live  = 1'b0;
        hit_mask  = '0;
        q_in      = 1'b0;
        q_alive_d = 1'b0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if ((|alive[r*COLS +: COLS]) && (32'(org_y) + 32'(r) * DY >= Y_LAND)) begin
                landed = 1'b1;
            end
            for (int c = 0; c < int'(COLS); c++) begin
                off = XW'(32'(c) * DX + ((r % 2 == 1) ? ROW_SHIFT : 0));
                if (alive[r*COLS+c]) begin
                    if (off > max_off) max_off = off;
                    if (off < min_off) min_off = off;
                end
                if (hit_row == RW'(r) && hit_col == CW'(c) && alive[r*COLS+c]) begin
                    hit_live           = 1'b1;
                    hit_mask[r*COLS+c] = 1'b1;
                end
                if (q_row == RW'(r) && q_col == CW'(c)) begin
                    q_in      = 1'b1;
                    q_alive_d = alive[r*COLS+c];
                end
            end
        end
        qx_calc   = org_x + XW'(32'(q_col) * DX) + (q_row[0] ? XW'(ROW_SHIFT) : '0);
        qy_calc   = org_y + XW'(32'(q_row) * DY);
        step_x    = XW'(speed) + XW'(1);
        right_s   = $signed(EW'(org_x) + EW'(max_off));
        left_s    = $signed(EW'(org_x) + EW'(min_off));
        step_s    = $signed(EW'(speed) + EW'(1));
        can_right = (right_s + step_s) <= $signed(EW'(X_MAX));
        can_left  = (left_s - step_s) >= $signed(EW'(X_MIN));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            org_x        <= XW'(X_INIT);
            org_y        <= XW'(Y_INIT);
            alive        <= '1;
            alive_count  <= NW'(N);
            direction    <= 1'b0;
            speed        <= '0;
            pend_descent <= 1'b0;
            move_cnt     <= '0;
            hit_ack      <= 1'b0;
            q_x          <= '0;
            q_y          <= '0;
            q_alive      <= 1'b0;
        end else begin
            hit_ack <= 1'b0;
            q_x     <= q_in ? qx_calc : '0;
            q_y     <= q_in ? qy_calc : '0;
            q_alive <= q_in & q_alive_d;
            case (state_q)
                StIdle: begin
                    if (start) state_q <= StMarch;
                end
                StMarch: begin
                    // Exits are decided on registered values and freeze the formation at once.
                    if (alive == '0) begin
                        state_q <= StCleared;
                    end else if (landed) begin
                        state_q <= StLanded;
                    end else begin
                        if (hit_valid && hit_live) begin
                            alive       <= alive & ~hit_mask;
                            alive_count <= alive_count - NW'(1);
                            hit_ack     <= 1'b1;
                        end
                        if (!pause) begin
                            if (move_cnt == MW'(MOVE_PERIOD - 1)) begin
                                move_cnt <= '0;
                                if (pend_descent) begin
                                    org_y        <= org_y + XW'(DESCEND);
                                    speed        <= (speed == SW'(SPEED_MAX)) ? speed
                                                                              : speed + SW'(1);
                                    pend_descent <= 1'b0;
                                end else if (!direction) begin
                                    if (can_right) begin
                                        org_x <= org_x + step_x;
                                    end else begin
                                        direction    <= 1'b1;
                                        pend_descent <= 1'b1;
                                    end
                                end else begin
                                    if (can_left) begin
                                        org_x <= org_x - step_x;
                                    end else begin
                                        direction    <= 1'b0;
                                        pend_descent <= 1'b1;
                                    end
                                end
                            end else begin
                                move_cnt <= move_cnt + MW'(1);
                            end
                        end
                    end
                end
                StCleared, StLanded: begin
                    if (start) begin
                        state_q      <= StMarch;
                        org_x        <= XW'(X_INIT);
                        org_y        <= XW'(Y_INIT);
                        alive        <= '1;
                        alive_count  <= NW'(N);
                        direction    <= 1'b0;
                        speed        <= '0;
                        pend_descent <= 1'b0;
                        move_cnt     <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
